// File: rtl/store_pack_buf.sv
// store_pack_buf: packs sw/sh/sb stores into lane-replicated data plus byte enables and queues them toward data memory
//   clk, reset             : clock, synchronous active-high reset
//   st_valid/st_op/st_addr/st_data : store from MEM stage (op 00=sw, 01=sh, 10=sb, 11=dropped)
//   st_stall               : FIFO full, pipeline holds the store
//   misalign               : one-cycle pulse after a misaligned store (STORE_MISALIGN_EXC_EN only)
//   dm_valid/dm_ready      : head-entry handshake toward data memory
//   dm_addr/dm_wdata/dm_be : head entry (word address, replicated data, byte enables)
//   empty                  : no entries queued
// Define STORE_MISALIGN_EXC_EN to drop misaligned sw/sh and raise misalign.
module store_pack_buf #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_stall,
    output logic        misalign,
    output logic        dm_valid,
    input  logic        dm_ready,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [29:0]   addr_q  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic          misalign_q, misalign_d;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic          legal, mis, push, pop;

    always_comb begin
        legal = st_op != 2'b11;
`ifdef STORE_MISALIGN_EXC_EN
        mis = (st_op == 2'b00 && st_addr[1:0] != 2'b00) || (st_op == 2'b01 && st_addr[0]);
`else
        mis = 1'b0;
`endif
        be_d = st_op == 2'b00 ? 4'b1111 :
               st_op == 2'b01 ? (st_addr[1] ? 4'b1100 : 4'b0011) :
                                4'b0001 << st_addr[1:0];
        wdata_d = st_op == 2'b00 ? st_data :
                  st_op == 2'b01 ? {2{st_data[15:0]}} : {4{st_data[7:0]}};
        // A full FIFO blocks the push even when a pop happens the same cycle.
        push = st_valid && !st_stall && legal && !mis;
        pop = dm_valid && dm_ready;
        misalign_d = st_valid && !st_stall && legal && mis;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q]  <= st_addr[31:2];
            wdata_q[wr_ptr_q] <= wdata_d;
            be_q[wr_ptr_q]    <= be_d;
        end
    end

    assign st_stall = count_q == (AW+1)'(DEPTH);
    assign dm_valid = count_q != '0;
    assign empty    = !dm_valid;
    assign misalign = misalign_q;
    // Head fields read as zero when empty so stale storage never leaks out after reset.
    assign dm_addr  = dm_valid ? {addr_q[rd_ptr_q], 2'b00} : '0;
    assign dm_wdata = dm_valid ? wdata_q[rd_ptr_q] : '0;
    assign dm_be    = dm_valid ? be_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_store_pack_buf.sv
// tb_store_pack_buf: randomized scoreboard bench for store_pack_buf
module tb_store_pack_buf;
    localparam int DEPTH = 4;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
    } ent_t;

    logic        clk = 1'b0, reset = 1'b1, st_valid = 1'b0, dm_ready = 1'b0;
    logic [1:0]  st_op = 2'b00;
    logic [31:0] st_addr = '0, st_data = '0;
    logic        st_stall, misalign, dm_valid, empty;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;

    int   vectors = 0, miscompares = 0;
    ent_t exp_q[$];
    ent_t pend_e;
    logic pend_v = 1'b0, pend_rst = 1'b1, pend_mis = 1'b0, exp_mis = 1'b0, mon_en = 1'b0;

    always #5 clk = ~clk;

    store_pack_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
        .misalign(misalign), .dm_valid(dm_valid), .dm_ready(dm_ready),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .empty(empty)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, driven #1 after the edge. The store presented here
    // lands in the DUT at the next edge, so its expected entry is committed to
    // the scoreboard at the start of the following call.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic rs, output logic acc);
        int   n, occ;
        logic mis;
        @(posedge clk);
        #1;
        if (pend_rst) exp_q.delete();
        else if (pend_v) exp_q.push_back(pend_e);
        exp_mis = pend_mis;
        occ = exp_q.size();
        n = op == 2'd0 ? 4 : op == 2'd1 ? 2 : 1;
`ifdef STORE_MISALIGN_EXC_EN
        mis = op != 2'b11 && (int'(a[1:0]) % n) != 0;
`else
        mis = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            pend_e.be[i] = (i / n) == (int'(a[1:0]) / n);
            pend_e.wd[8*i +: 8] = d[8*(i % n) +: 8];
        end
        pend_e.addr = {a[31:2], 2'b00};
        acc = !rs && v && op != 2'b11 && !mis && occ < DEPTH;
        pend_v = acc;
        pend_rst = rs;
        pend_mis = !rs && v && op != 2'b11 && mis && occ < DEPTH;
        reset = rs;
        st_valid = v;
        st_op = op;
        st_addr = a;
        st_data = d;
        dm_ready = rdy;
    endtask

    task automatic idle(input logic rdy, input int k);
        logic acc;
        repeat (k) cyc(1'b0, 2'b00, 32'h0, 32'h0, rdy, 1'b0, acc);
    endtask

    // Monitor: checks the DUT against the scoreboard head away from the edge,
    // and retires the head at the edge where the handshake completes.
    initial begin
        ent_t h;
        logic wp;
        wait (mon_en);
        forever begin
            @(negedge clk);
            chk("dm_valid", dm_valid, exp_q.size() != 0);
            chk("empty", empty, exp_q.size() == 0);
            chk("st_stall", st_stall, exp_q.size() == DEPTH);
            chk("misalign", misalign, exp_mis);
            if (exp_q.size() != 0) h = exp_q[0];
            else h = '{32'h0, 32'h0, 4'h0};
            chk("dm_addr", dm_addr, h.addr);
            chk("dm_wdata", dm_wdata, h.wd);
            chk("dm_be", dm_be, h.be);
            wp = dm_valid && dm_ready;
            @(posedge clk);
            if (wp && exp_q.size() != 0) h = exp_q.pop_front();
        end
    end

    initial begin
        logic       acc, v, rdy, rs;
        logic [1:0] op;
        int         tries;
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        mon_en = 1'b1;
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        cyc(1'b1, 2'b10, 32'h1003, 32'h000000A5, 1'b0, 1'b0, acc);
        idle(1'b0, 2);
        cyc(1'b1, 2'b01, 32'h2002, 32'h1234BEEF, 1'b1, 1'b0, acc);
        cyc(1'b1, 2'b00, 32'h3000, 32'hCAFEF00D, 1'b1, 1'b0, acc);
        idle(1'b1, 3);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 2'b00, 32'h100 + 32'(4*i), 32'h11111111 * 32'(i+1), 1'b0, 1'b0, acc);
        repeat (3) cyc(1'b1, 2'b00, 32'h200, 32'h55555555, 1'b0, 1'b0, acc);
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cyc(1'b1, 2'b00, 32'h200, 32'h55555555, 1'b1, 1'b0, acc);
            tries++;
        end
        idle(1'b1, 6);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 2'b00, 32'h500 + 32'(4*i), $urandom, 1'b1, 1'b0, acc);
        idle(1'b1, 3);
        cyc(1'b1, 2'b00, 32'h4001, 32'hDEADBEEF, 1'b0, 1'b0, acc);
        idle(1'b0, 2);
        idle(1'b1, 3);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 2'b10, 32'h600 + 32'(i), 32'h77 + 32'(i), 1'b0, 1'b0, acc);
        cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, acc);
        idle(1'b1, 4);
        repeat (500) begin
            v = ($urandom % 4) != 0;
            op = 2'($urandom);
            rdy = ($urandom % 3) != 0;
            rs = ($urandom % 60) == 0;
            cyc(v, op, $urandom, $urandom, rdy, rs, acc);
        end
        tries = 0;
        while ((exp_q.size() != 0 || pend_v) && tries < 3 * DEPTH) begin
            idle(1'b1, 1);
            tries++;
        end
        if (exp_q.size() != 0 || pend_v) begin
            miscompares++;
            $display("FAIL drain: %0d entries still expected after timeout", exp_q.size());
        end
        idle(1'b0, 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
